game_timer_bcd: RTL and testbench
=================================

Name: game_timer_bcd

Overview:
Parametrised successor to the seconds counter used by the card-flip game. It divides the system clock into a seconds tick and keeps an N-digit decimal (BCD) elapsed or remaining time. It supports count-up and count-down modes, pause/resume, a preset load and a timeout flag. It drives a packed bank of active-low 7-segment digit patterns, with optional leading-zero blanking, for the HEX displays. It sits between the game FSM (start/end/pause strobes) and the board displays.

Parameters:
CLK_HZ, 50000000, clock cycles per seconds tick (divider terminal count = CLK_HZ-1)
NUM_DIGITS, 4, number of BCD digits kept and displayed (1..6)
BLANK_LEADING, 1, 1 = blank leading zero digits (digit 0 is always shown); 0 = show all digits

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
game_start  in  1  single-cycle strobe: start timing from the loaded value
game_end  in  1  single-cycle strobe: stop timing, hold value
pause  in  1  level: while high in RUNNING, freeze divider and count
count_down  in  1  mode, sampled only on game_start: 0 = up, 1 = down
preset  in  4*NUM_DIGITS  BCD start value for down mode, sampled on game_start
bcd_count  out  4*NUM_DIGITS  current time, digit 0 in [3:0]
running  out  1  high in RUNNING state only
timeout  out  1  sticky: down count reached 0, or up count saturated at all 9s
hex_out  out  7*NUM_DIGITS  active-low segments, digit i in [7i+6:7i], bit order gfedcba

Behaviour:
- Reset (async, active-high): state IDLE; divider = 0; bcd_count = 0; running = 0; timeout = 0; latched mode = up.
- States: IDLE, RUNNING, PAUSED, DONE.
- game_start in any state:
  - enter RUNNING; divider cleared to 0; timeout cleared.
  - Latch count_down. bcd_count = preset in down mode, 0 in up mode.
  - game_start has priority over game_end and pause in the same cycle.
  - A preset of 0 in down mode goes straight to DONE with timeout = 1 on the next cycle.
- RUNNING:
  - divider increments each cycle; at CLK_HZ-1 it wraps to 0 and produces a 1-cycle tick.
  - On tick, up mode: BCD increment with per-digit carry (9 -> 0, carry to next digit).
  - On tick, down mode: BCD decrement with per-digit borrow (0 -> 9, borrow from next digit).
  - pause = 1: go to PAUSED; divider holds its value (partial second is preserved).
  - game_end: go to DONE; bcd_count holds; a tick coincident with game_end is discarded.
- PAUSED:
  - divider and count hold; running = 0.
  - pause = 0: return to RUNNING and resume the divider from the held value.
  - game_end: go to DONE.
- DONE: count holds; only game_start leaves DONE. IDLE behaves the same as DONE.
- Terminal conditions (no wrap-around):
  - Up mode, a tick while bcd_count is all 9s: count stays all 9s; timeout = 1; state goes to DONE.
  - Down mode, the tick that makes bcd_count 0: timeout = 1 and state goes to DONE in that same edge.
- Invalid BCD digits in preset (A-F) are out of contract; the decrement logic need only avoid lock-up.
- hex_out:
  - Combinational from bcd_count. Patterns 0-9 are the standard active-low codes (0 = 1000000, 1 = 1111001, ..., 9 = 0010000).
  - A blanked digit = 1111111. With BLANK_LEADING = 1, digit i (i > 0) is blanked when it and all higher digits are 0.
- Latency: bcd_count and timeout update on the clock edge after the divider reaches CLK_HZ-1 (one tick per CLK_HZ cycles); running updates one edge after the causing strobe.

Test Plan:
- CLK_HZ = 4, NUM_DIGITS = 4, up mode, game_start at cycle 0 -> bcd_count = 0001 after 4 cycles; 0010 after 40 cycles; hex_out digit 0 = 1000000; digits 2-3 = 1111111.
- CLK_HZ = 4, preset = 0x0012, down mode -> 0011, 0010, 0009 at 4-cycle steps; reaches 0000 after 48 cycles with timeout = 1, running = 0, and count holds.
- Up mode with a 2-digit instance, run past 99 -> stays 99, timeout = 1, state DONE; a following game_start clears timeout and restarts from 00.
- Pause asserted with divider = 2 for 10 cycles, then released -> next tick 2 cycles after release; count unchanged during pause.
- game_start and game_end asserted in the same cycle -> RUNNING (start wins); game_end coincident with a tick -> count not incremented.
- Assert reset mid-count at an arbitrary (non-clock-aligned) time -> bcd_count = 0, running = 0, timeout = 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/game_timer_bcd.sv
// Seconds timer for the card-flip game: N-digit BCD up/down count with pause,
// preset, sticky timeout and active-low 7-segment outputs.
//
// state   | meaning
// IDLE    | after reset, count held, waiting for game_start
// RUNNING | divider advancing, count updates on each tick
// PAUSED  | divider and count frozen while pause is high
// DONE    | game ended or terminal count reached, count held
module game_timer_bcd #(
  parameter int CLK_HZ        = 50000000,
  parameter int NUM_DIGITS    = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    game_start,
  input  logic                    game_end,
  input  logic                    pause,
  input  logic                    count_down,
  input  logic [4*NUM_DIGITS-1:0] preset,
  output logic [4*NUM_DIGITS-1:0] bcd_count,
  output logic                    running,
  output logic                    timeout,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int BW    = 4 * NUM_DIGITS;
  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_HZ - 1);
  localparam logic [BW-1:0]    ALL_NINES = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             mode_q, mode_d;
  logic [BW-1:0]    cnt_dec;

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Invalid digits simply step down by one, so a bad preset still drains to 0.
  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      mode_q  <= mode_d;
    end
  end

  assign cnt_dec = bcd_dec(cnt_q);

  // PAUSED with pause low resumes and advances the divider in the same edge.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    mode_d  = mode_q;
    if (game_start) begin
      state_d = RUNNING;
      div_d   = '0;
      to_d    = 1'b0;
      mode_d  = count_down;
      cnt_d   = count_down ? preset : '0;
    end else if (state_q == RUNNING || state_q == PAUSED) begin
      if (game_end) begin
        state_d = DONE;
      end else if (mode_q && cnt_q == '0) begin
        state_d = DONE;
        to_d    = 1'b1;
      end else if (pause) begin
        state_d = PAUSED;
      end else begin
        state_d = RUNNING;
        if (div_q == DIV_MAX) begin
          div_d = '0;
          if (!mode_q) begin
            if (cnt_q == ALL_NINES) begin
              to_d    = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d = bcd_inc(cnt_q);
            end
          end else begin
            cnt_d = cnt_dec;
            if (cnt_dec == '0) begin
              to_d    = 1'b1;
              state_d = DONE;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end
  end

  always_comb begin : hex_decode
    logic lead_zero;
    lead_zero = 1'b1;
    hex_out   = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead_zero = lead_zero && (cnt_q[4*i +: 4] == 4'd0);
      if (BLANK_LEADING && i > 0 && lead_zero) begin
        hex_out[7*i +: 7] = 7'b1111111;
      end else begin
        hex_out[7*i +: 7] = seg7(cnt_q[4*i +: 4]);
      end
    end
  end

  assign bcd_count = cnt_q;
  assign running   = (state_q == RUNNING);
  assign timeout   = to_q;

endmodule

// File: tb/tb_game_timer_bcd.sv
// Directed bench for game_timer_bcd: a 4-digit blanked instance for the main
// timing scenarios and a 2-digit unblanked instance for saturation.
module tb_game_timer_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gs = 1'b0, ge = 1'b0, pz = 1'b0, cd = 1'b0;
  logic [15:0] preset = '0;
  logic [15:0] bcd;
  logic        run, to;
  logic [27:0] hex;

  logic        gs2 = 1'b0;
  logic        ge2 = 1'b0, pz2 = 1'b0, cd2 = 1'b0;
  logic [7:0]  preset2 = '0;
  logic [7:0]  bcd2;
  logic        run2, to2;
  logic [13:0] hex2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_timer_bcd #(.CLK_HZ(4), .NUM_DIGITS(4), .BLANK_LEADING(1'b1)) u_dut (
    .clk(clk), .reset(reset), .game_start(gs), .game_end(ge), .pause(pz),
    .count_down(cd), .preset(preset), .bcd_count(bcd), .running(run),
    .timeout(to), .hex_out(hex)
  );

  game_timer_bcd #(.CLK_HZ(4), .NUM_DIGITS(2), .BLANK_LEADING(1'b0)) u_sat (
    .clk(clk), .reset(reset), .game_start(gs2), .game_end(ge2), .pause(pz2),
    .count_down(cd2), .preset(preset2), .bcd_count(bcd2), .running(run2),
    .timeout(to2), .hex_out(hex2)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_main(input logic down, input logic [15:0] pv);
    cd = down;
    preset = pv;
    gs = 1'b1;
    step(1);
    gs = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL rst_bcd got=%h exp=%h", bcd, 16'h0000); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL rst_running got=%b exp=0", run); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", to); end
    checks++; if (hex !== {7'h7f, 7'h7f, 7'h7f, 7'h40}) begin errors++; $display("FAIL rst_hex got=%h exp=%h", hex, {7'h7f, 7'h7f, 7'h7f, 7'h40}); end
    checks++; if (hex2 !== {7'h40, 7'h40}) begin errors++; $display("FAIL rst_hex_noblank got=%h exp=%h", hex2, {7'h40, 7'h40}); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_up_count();
    start_main(1'b0, 16'h0000);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL up_running got=%b exp=1", run); end
    step(3);
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL up_pre_tick got=%h exp=%h", bcd, 16'h0000); end
    step(1);
    checks++; if (bcd !== 16'h0001) begin errors++; $display("FAIL up_1s got=%h exp=%h", bcd, 16'h0001); end
    step(36);
    checks++; if (bcd !== 16'h0010) begin errors++; $display("FAIL up_10s got=%h exp=%h", bcd, 16'h0010); end
    checks++; if (hex !== {7'h7f, 7'h7f, 7'h79, 7'h40}) begin errors++; $display("FAIL up_hex got=%h exp=%h", hex, {7'h7f, 7'h7f, 7'h79, 7'h40}); end
  endtask

  task automatic test_start_end();
    cd = 1'b0;
    gs = 1'b1;
    ge = 1'b1;
    step(1);
    gs = 1'b0;
    ge = 1'b0;
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL start_wins_running got=%b exp=1", run); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL start_wins_bcd got=%h exp=%h", bcd, 16'h0000); end
    step(3);
    ge = 1'b1;
    step(1);
    ge = 1'b0;
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL end_on_tick_bcd got=%h exp=%h", bcd, 16'h0000); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL end_on_tick_running got=%b exp=0", run); end
    step(5);
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL done_hold_bcd got=%h exp=%h", bcd, 16'h0000); end
  endtask

  task automatic test_pause();
    start_main(1'b0, 16'h0000);
    step(2);
    pz = 1'b1;
    step(10);
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL pause_running got=%b exp=0", run); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL pause_bcd got=%h exp=%h", bcd, 16'h0000); end
    pz = 1'b0;
    step(1);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL resume_running got=%b exp=1", run); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL resume_early got=%h exp=%h", bcd, 16'h0000); end
    step(1);
    checks++; if (bcd !== 16'h0001) begin errors++; $display("FAIL resume_tick got=%h exp=%h", bcd, 16'h0001); end
  endtask

  task automatic test_down_count();
    start_main(1'b1, 16'h0012);
    cd = 1'b0;
    checks++; if (bcd !== 16'h0012) begin errors++; $display("FAIL down_load got=%h exp=%h", bcd, 16'h0012); end
    step(4);
    checks++; if (bcd !== 16'h0011) begin errors++; $display("FAIL down_11 got=%h exp=%h", bcd, 16'h0011); end
    step(4);
    checks++; if (bcd !== 16'h0010) begin errors++; $display("FAIL down_10 got=%h exp=%h", bcd, 16'h0010); end
    step(4);
    checks++; if (bcd !== 16'h0009) begin errors++; $display("FAIL down_borrow got=%h exp=%h", bcd, 16'h0009); end
    checks++; if (hex !== {7'h7f, 7'h7f, 7'h7f, 7'h10}) begin errors++; $display("FAIL down_hex9 got=%h exp=%h", hex, {7'h7f, 7'h7f, 7'h7f, 7'h10}); end
    step(35);
    checks++; if (bcd !== 16'h0001 || to !== 1'b0) begin errors++; $display("FAIL down_1 got=%h/%b exp=0001/0", bcd, to); end
    step(1);
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL down_zero got=%h exp=%h", bcd, 16'h0000); end
    checks++; if (to !== 1'b1) begin errors++; $display("FAIL down_timeout got=%b exp=1", to); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL down_running got=%b exp=0", run); end
    step(8);
    checks++; if (bcd !== 16'h0000 || to !== 1'b1) begin errors++; $display("FAIL down_hold got=%h/%b exp=0000/1", bcd, to); end
  endtask

  task automatic test_preset_zero();
    start_main(1'b1, 16'h0000);
    checks++; if (run !== 1'b1 || to !== 1'b0) begin errors++; $display("FAIL pz_start got=%b/%b exp=1/0", run, to); end
    step(1);
    checks++; if (run !== 1'b0 || to !== 1'b1) begin errors++; $display("FAIL pz_done got=%b/%b exp=0/1", run, to); end
    cd = 1'b0;
  endtask

  task automatic test_saturate();
    gs2 = 1'b1;
    step(1);
    gs2 = 1'b0;
    step(396);
    checks++; if (bcd2 !== 8'h99 || to2 !== 1'b0 || run2 !== 1'b1) begin errors++; $display("FAIL sat_99 got=%h/%b/%b exp=99/0/1", bcd2, to2, run2); end
    step(4);
    checks++; if (bcd2 !== 8'h99) begin errors++; $display("FAIL sat_hold got=%h exp=%h", bcd2, 8'h99); end
    checks++; if (to2 !== 1'b1 || run2 !== 1'b0) begin errors++; $display("FAIL sat_flags got=%b/%b exp=1/0", to2, run2); end
    checks++; if (hex2 !== {7'h10, 7'h10}) begin errors++; $display("FAIL sat_hex got=%h exp=%h", hex2, {7'h10, 7'h10}); end
    step(4);
    checks++; if (bcd2 !== 8'h99) begin errors++; $display("FAIL sat_stay got=%h exp=%h", bcd2, 8'h99); end
    gs2 = 1'b1;
    step(1);
    gs2 = 1'b0;
    checks++; if (bcd2 !== 8'h00 || to2 !== 1'b0 || run2 !== 1'b1) begin errors++; $display("FAIL sat_restart got=%h/%b/%b exp=00/0/1", bcd2, to2, run2); end
    checks++; if (hex2 !== {7'h40, 7'h40}) begin errors++; $display("FAIL sat_restart_hex got=%h exp=%h", hex2, {7'h40, 7'h40}); end
  endtask

  task automatic test_async_reset();
    start_main(1'b0, 16'h0000);
    step(10);
    checks++; if (bcd !== 16'h0002) begin errors++; $display("FAIL ar_pre got=%h exp=%h", bcd, 16'h0002); end
    #3 reset = 1'b1;
    #1;
    checks++; if (bcd !== 16'h0000 || run !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL ar_main got=%h/%b/%b exp=0000/0/0", bcd, run, to); end
    checks++; if (bcd2 !== 8'h00 || run2 !== 1'b0 || to2 !== 1'b0) begin errors++; $display("FAIL ar_sat got=%h/%b/%b exp=00/0/0", bcd2, run2, to2); end
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_start_end();
    test_pause();
    test_down_count();
    test_preset_zero();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
